pkt_stream_arbiter: RTL
=======================

PKT_STREAM_ARBITER -- requirements
Module: pkt_stream_arbiter

Interface
REQ-001 SHALL have parameters: NUM_PORTS, 4, number of input packet streams (2..16); SYMBOLS_PER_BEAT, 64, symbols per beat; BITS_PER_SYMBOL, 8, bits per symbol.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports listed in REQ-003..REQ-008.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_data  input  NUM_PORTS x SYMBOLS_PER_BEAT*BITS_PER_SYMBOL  per-port beat data; in_valid, in_startofpacket, in_endofpacket  input  NUM_PORTS  per-port flags; in_empty  input  NUM_PORTS x $clog2(SYMBOLS_PER_BEAT)  per-port empty symbols.
REQ-006 in_ready  output  NUM_PORTS  per-port accept.
REQ-007 out_data, out_valid, out_startofpacket, out_endofpacket, out_empty  output  widths as one input port  merged stream; out_ready  input  1  sink accept; out_almost_full  input  1  downstream packet-FIFO occupancy flag.
REQ-008 grant_port  output  $clog2(NUM_PORTS)  current owner; drop_pulse  output  1  one-cycle pulse per discarded beat; pkt_count  output  NUM_PORTS x 32  per-port forwarded-packet counters.

Function
REQ-009 SHALL arbitrate at packet granularity; a packet, once started, SHALL never be interleaved with another port's beats.
REQ-010 FSM states SHALL be IDLE and LOCKED.
REQ-011 In IDLE, port i SHALL request when in_valid[i] & in_startofpacket[i].
REQ-012 In IDLE with out_almost_full==0 and at least one request, SHALL register grant to the first requester at or after rr_ptr (wrapping modulo NUM_PORTS) and enter LOCKED next cycle; zero data beats move in the grant cycle.
REQ-013 In IDLE with out_almost_full==1, SHALL issue no grant; out_almost_full SHALL be ignored in LOCKED.
REQ-014 In LOCKED, out_* SHALL be a combinational mux of granted port g, in_ready[g]=out_ready, and in_ready of all other ports SHALL be 0.
REQ-015 On the accepted beat (valid & ready) with in_endofpacket[g]=1, SHALL return to IDLE and set rr_ptr=(g+1) mod NUM_PORTS; a single-beat packet (sop&eop) SHALL complete in one LOCKED cycle.
REQ-016 In IDLE, a port with in_valid=1 and in_startofpacket=0 SHALL get in_ready=1, its beat discarded, and drop_pulse asserted that cycle; out_valid SHALL be 0 in IDLE.
REQ-017 An in_startofpacket beat arriving mid-packet on the granted port SHALL be forwarded unchanged (no repair).
REQ-018 Throughput in LOCKED SHALL be one beat per cycle when in_valid[g] & out_ready; arbitration overhead SHALL be exactly one cycle per packet.

Reset
REQ-019 On rst_n low, SHALL asynchronously force IDLE, rr_ptr=0, grant_port=0, in_ready=0, out_valid=0, drop_pulse=0, pkt_count=0.
REQ-020 Reset mid-packet SHALL abandon the packet; after release, remaining non-sop beats of it SHALL be dropped per REQ-016.

Configuration
REQ-021 Macro PKT_ARB_STATS_EN: when defined, pkt_count[i] SHALL increment (wrapping at 2^32) on every accepted eop beat from port i; when undefined, pkt_count SHALL be constant 0 and no counter registers synthesized.

Structure
REQ-022 Shared package pkt_arb_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and the beat struct (sop, eop, empty, data), parameterized by width localparams.
REQ-023 Round-robin priority selection SHALL be a sub-module rr_pick (request vector, rr_ptr -> one-hot grant, valid), purely combinational.

Verification
REQ-024 Ports 0 and 2 each present a 3-beat packet simultaneously, rr_ptr=0 -> grant port 0 one cycle, 3 beats out, IDLE one cycle, then port 2's 3 beats; rr_ptr ends at 3.
REQ-025 out_almost_full=1 in IDLE with port 1 requesting -> no grant, in_ready=0, out_valid=0; deassert -> grant port 1 next cycle; asserting it mid-packet -> packet completes.
REQ-026 Port 3 sends a single-beat packet (sop&eop) with out_ready=1 -> one output beat with sop=eop=1, return to IDLE, rr_ptr wraps to 0.
REQ-027 Port 1 presents non-sop beat in IDLE -> in_ready[1]=1, drop_pulse=1 one cycle, no output.
REQ-028 out_ready held 0 for 5 cycles mid-packet -> out_data stable, in_ready[g]=0, no beat loss; rst_n asserted mid-packet -> all outputs reset immediately, pkt_count=0.
REQ-029 With PKT_ARB_STATS_EN, 10 packets from port 0 and 4 from port 2 -> pkt_count[0]=10, pkt_count[2]=4, others 0; without the macro all 0.

Source files
------------

// File: rtl/pkt_stream_arbiter_pkg.sv
// Shared types for the packet stream arbiter: FSM state, beat layout and
// the round-robin pointer wrap helper.
package pkt_arb_pkg;

    localparam int BEAT_SYMBOLS = 64;
    localparam int SYMBOL_BITS  = 8;
    localparam int BEAT_DATA_W  = BEAT_SYMBOLS * SYMBOL_BITS;
    localparam int BEAT_EMPTY_W = $clog2(BEAT_SYMBOLS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [BEAT_EMPTY_W-1:0] empty;
        logic [BEAT_DATA_W-1:0]  data;
    } beat_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/pkt_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or
// after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 vld
);

    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS streams into one.
// Define PKT_ARB_STATS_EN to build the per-port forwarded-packet counters.
module pkt_stream_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int SYMBOLS_PER_BEAT = 64,
    parameter int BITS_PER_SYMBOL  = 8
) (
    input  logic                                                       clk,
    input  logic                                                       rst_n,
    input  logic [NUM_PORTS-1:0][SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] in_data,
    input  logic [NUM_PORTS-1:0]                                       in_valid,
    input  logic [NUM_PORTS-1:0]                                       in_startofpacket,
    input  logic [NUM_PORTS-1:0]                                       in_endofpacket,
    input  logic [NUM_PORTS-1:0][$clog2(SYMBOLS_PER_BEAT)-1:0]         in_empty,
    output logic [NUM_PORTS-1:0]                                       in_ready,
    output logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0]                out_data,
    output logic                                                       out_valid,
    output logic                                                       out_startofpacket,
    output logic                                                       out_endofpacket,
    output logic [$clog2(SYMBOLS_PER_BEAT)-1:0]                        out_empty,
    input  logic                                                       out_ready,
    input  logic                                                       out_almost_full,
    output logic [$clog2(NUM_PORTS)-1:0]                               grant_port,
    output logic                                                       drop_pulse,
    output logic [NUM_PORTS-1:0][31:0]                                 pkt_count
);

    localparam int PW = $clog2(NUM_PORTS);

    arb_state_e           state, state_nxt;
    logic [PW-1:0]        rr_ptr, rr_nxt, grant_nxt, pick_idx;
    logic [NUM_PORTS-1:0] pick_oh;
    logic                 pick_vld;
    logic                 pkt_done;

    rr_pick #(.N(NUM_PORTS)) u_rr_pick (
        .req (in_valid & in_startofpacket),
        .ptr (rr_ptr),
        .gnt (pick_oh),
        .vld (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (pick_oh[i]) pick_idx = PW'(i);
    end

    assign pkt_done = (state == LOCKED) && in_valid[grant_port] && out_ready
                      && in_endofpacket[grant_port];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_port <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            grant_port <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        rr_nxt            = rr_ptr;
        grant_nxt         = grant_port;
        in_ready          = '0;
        drop_pulse        = 1'b0;
        out_valid         = 1'b0;
        out_data          = in_data[grant_port];
        out_startofpacket = in_startofpacket[grant_port];
        out_endofpacket   = in_endofpacket[grant_port];
        out_empty         = in_empty[grant_port];
        case (state)
            IDLE: begin
                // Beats that are not a packet start have no owner: sink and flag them.
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (rst_n && in_valid[i] && !in_startofpacket[i]) begin
                        in_ready[i] = 1'b1;
                        drop_pulse  = 1'b1;
                    end
                end
                if (!out_almost_full && pick_vld) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick_idx;
                end
            end
            LOCKED: begin
                out_valid            = in_valid[grant_port];
                in_ready[grant_port] = out_ready;
                if (pkt_done) begin
                    state_nxt = IDLE;
                    rr_nxt    = PW'(wrap_inc(int'(grant_port), NUM_PORTS));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PKT_ARB_STATS_EN
    logic [NUM_PORTS-1:0][31:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pkt_cnt_q <= '0;
        else if (pkt_done)
            pkt_cnt_q[grant_port] <= pkt_cnt_q[grant_port] + 32'd1;
    end

    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = '0;
`endif

endmodule
